// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the bit-serial ALU (serial_alu_ctrl).
package alu_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit function slice. SERIAL_ALU_ADD_EN enables the ADD path
// (with carry in/out); otherwise opcode 11 is XNOR and the carry ports are absent.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
`ifdef SERIAL_ALU_ADD_EN
   input  logic       cin,
`endif
   input  logic [1:0] op,
   output logic       out
`ifdef SERIAL_ALU_ADD_EN
   ,
   output logic       cout
`endif
);

   always_comb begin
      out = 1'b0;
`ifdef SERIAL_ALU_ADD_EN
      cout = 1'b0;
`endif
      case (op_t'(op))
         OP_AND: out = a & b;
         OP_OR:  out = a | b;
         OP_XOR: out = a ^ b;
         OP_ADD: begin
`ifdef SERIAL_ALU_ADD_EN
            out  = a ^ b ^ cin;
            cout = (a & b) | (a & cin) | (b & cin);
`else
            out  = ~(a ^ b);
`endif
         end
         default: out = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one alu_bit_slice, LSB-first, WIDTH cycles per op.
// SERIAL_ALU_ADD_EN compiles in the carry register and makes opcode 11 an ADD.
module serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state;
   op_t              op_r;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic [CW-1:0]    cnt;
   logic             slice_out;
   logic             last;
`ifdef SERIAL_ALU_ADD_EN
   logic             carry;
   logic             slice_cout;
   logic             carry_next;
`endif

   alu_bit_slice u_slice (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
`ifdef SERIAL_ALU_ADD_EN
      .cin  (carry),
`endif
      .op   (op_r),
      .out  (slice_out)
`ifdef SERIAL_ALU_ADD_EN
      ,
      .cout (slice_cout)
`endif
   );

   // Slice bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
   assign work_next = {slice_out, work[WIDTH-1:1]};
   assign last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
`ifdef SERIAL_ALU_ADD_EN
   assign carry_next = (op_r == OP_ADD) ? slice_cout : 1'b0;
`else
   assign carry_out  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_r   <= OP_AND;
         a_sh   <= '0;
         b_sh   <= '0;
         work   <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
`ifdef SERIAL_ALU_ADD_EN
         carry     <= 1'b0;
         carry_out <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  op_r  <= op_t'(op);
                  a_sh  <= a;
                  b_sh  <= b;
                  work  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
`ifdef SERIAL_ALU_ADD_EN
                  carry <= 1'b0;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               work <= work_next;
`ifdef SERIAL_ALU_ADD_EN
               carry <= carry_next;
`endif
               if (last) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= work_next;
                  zero   <= (work_next == '0);
`ifdef SERIAL_ALU_ADD_EN
                  carry_out <= carry_next;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (WIDTH=8) against a word-level model.
module tb_serial_alu_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         zero;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero)
   );

   // Word-level reference: {carry, result}.
   function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
         2'b00:   return {1'b0, x & y};
         2'b01:   return {1'b0, x | y};
         2'b10:   return {1'b0, x ^ y};
`ifdef SERIAL_ALU_ADD_EN
         default: return {1'b0, x} + {1'b0, y};
`else
         default: return {1'b0, ~(x ^ y)};
`endif
      endcase
   endfunction

   // Call at a negedge. Returns busy-cycle count, cycle of done (-1 if none
   // within 40) and whether result moved before done.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int busy_cycles, output int done_at, output bit moved);
      logic [W-1:0] prev;
      prev  = result;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      busy_cycles = 0;
      done_at     = -1;
      moved       = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) begin
            done_at = c;
            break;
         end
         if (result !== prev) moved = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, done, result, carry_out, zero} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h carry=%b zero=%b, expected all 0",
                  busy, done, result, carry_out, zero);
      end
   endtask

   task automatic test_xor();
      int bc, da; bit mv;
      run_op(2'b10, 8'hA5, 8'h0F, bc, da, mv);
      tests++;
      if (bc !== 8 || da !== 9) begin
         fails++; $display("FAIL xor_latency: got busy=%0d done_at=%0d, expected 8 and 9", bc, da);
      end
      tests++;
      if ({result, zero, carry_out} !== {8'hAA, 1'b0, 1'b0}) begin
         fails++; $display("FAIL xor_result: got %h z=%b c=%b, expected aa z=0 c=0", result, zero, carry_out);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || result !== 8'hAA) begin
         fails++; $display("FAIL xor_pulse_hold: got done=%b result=%h, expected 0 and aa", done, result);
      end
   endtask

   task automatic test_and_or();
      int bc, da; bit mv;
      run_op(2'b00, 8'hF0, 8'h0F, bc, da, mv);
      tests++;
      if ({result, zero} !== {8'h00, 1'b1} || da !== 9) begin
         fails++; $display("FAIL and_result: got %h z=%b at %0d, expected 00 z=1 at 9", result, zero, da);
      end
      @(negedge clk);
      run_op(2'b01, 8'hF0, 8'h0F, bc, da, mv);
      tests++;
      if ({result, zero} !== {8'hFF, 1'b0} || da !== 9) begin
         fails++; $display("FAIL or_result: got %h z=%b at %0d, expected ff z=0 at 9", result, zero, da);
      end
   endtask

   task automatic test_op3();
      logic [W-1:0] xs [3] = '{8'hFF, 8'h12, 8'hF0};
      logic [W-1:0] ys [3] = '{8'h01, 8'h34, 8'h0F};
      logic [W:0]   exp;
      int bc, da; bit mv;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         run_op(2'b11, xs[i], ys[i], bc, da, mv);
         exp = model(2'b11, xs[i], ys[i]);
         tests++;
         if ({carry_out, result} !== exp || zero !== (exp[W-1:0] == '0) || da !== 9) begin
            fails++;
            $display("FAIL op3_%0d: got c=%b r=%h z=%b at %0d, expected c=%b r=%h z=%b at 9",
                     i, carry_out, result, zero, da, exp[W], exp[W-1:0], exp[W-1:0] == '0);
         end
      end
   endtask

   task automatic test_start_ignored();
      int dcount, first;
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h0F; b = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      dcount = 0; first = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done) begin
            dcount++;
            if (first < 0) first = c;
         end
         if (c == 3) begin
            start = 1'b1; op = 2'b00; a = W'($urandom); b = W'($urandom);
         end
         if (c == 4) start = 1'b0;
      end
      tests++;
      if (dcount !== 1 || first !== 9 || result !== 8'h0E) begin
         fails++;
         $display("FAIL start_ignored: got dones=%0d first=%0d result=%h, expected 1, 9, 0e", dcount, first, result);
      end
   endtask

   task automatic test_rst_abort();
      int dcount;
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h3C; b = 8'hC5;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({busy, done, result, carry_out, zero} !== '0) begin
         fails++;
         $display("FAIL rst_abort_outputs: got busy=%b done=%b result=%h carry=%b zero=%b, expected all 0",
                  busy, done, result, carry_out, zero);
      end
      dcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcount++;
      end
      tests++;
      if (dcount !== 0) begin
         fails++; $display("FAIL rst_abort_no_done: got %0d done pulses, expected 0", dcount);
      end
   endtask

   task automatic test_back_to_back();
      int bc, da; bit mv;
      run_op(2'b10, 8'h5A, 8'h0F, bc, da, mv);
      tests++;
      if (result !== 8'h55 || da !== 9) begin
         fails++; $display("FAIL b2b_first: got %h at %0d, expected 55 at 9", result, da);
      end
      run_op(2'b10, 8'h33, 8'h33, bc, da, mv);
      tests++;
      if ({result, zero} !== {8'h00, 1'b1} || da !== 9 || bc !== 8 || mv) begin
         fails++;
         $display("FAIL b2b_second: got %h z=%b at %0d busy=%0d moved=%b, expected 00 z=1 at 9 busy=8 moved=0",
                  result, zero, da, bc, mv);
      end
   endtask

   task automatic test_random();
      logic [1:0]   o;
      logic [W-1:0] x, y;
      logic [W:0]   exp;
      int bc, da; bit mv;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         o = 2'($urandom);
         x = W'($urandom);
         y = W'($urandom);
         run_op(o, x, y, bc, da, mv);
         exp = model(o, x, y);
         tests++;
         if ({carry_out, result} !== exp || zero !== (exp[W-1:0] == '0) || da !== 9 || bc !== 8 || mv) begin
            fails++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got c=%b r=%h z=%b at %0d busy=%0d moved=%b, expected c=%b r=%h z=%b at 9 busy=8 moved=0",
                     i, o, x, y, carry_out, result, zero, da, bc, mv, exp[W], exp[W-1:0], exp[W-1:0] == '0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_xor();
      test_and_or();
      test_op3();
      test_start_ignored();
      test_rst_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial ALU sequencer that sits directly upstream of the team's 1-bit logic units: it latches two WIDTH-bit operands and an opcode, feeds one bit pair per cycle (LSB first) into a 1-bit function slice, and shifts the slice output into a result register. It replaces a WIDTH-wide parallel datapath with one slice plus a counter and FSM. It signals completion with a one-cycle pulse and holds the result until the next operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range is 2 to 32.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request to begin an operation; accepted only in IDLE or DONE.
- op  input  2  opcode, sampled at accept: 00 AND, 01 OR, 10 XOR, 11 ADD (see Configuration).
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in the DONE state.
- result  output  WIDTH  final result, held between operations.
- carry_out  output  1  final carry (ADD only, otherwise 0).
- zero  output  1  high when result == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN.
  - RUN: runs for WIDTH cycles, then → DONE.
  - DONE: lasts exactly one cycle. start=1 → RUN (back-to-back accept); otherwise → IDLE.
- Accept (start=1 in IDLE or DONE):
  - Latch a, b and op into shift registers.
  - Clear bit counter, working carry and working result.
- Each RUN cycle:
  - The slice computes f(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one.
  - The slice bit enters the working result at the MSB, with a right shift.
  - For ADD, carry takes the slice carry; for other ops it stays 0.
  - The counter increments.
- RUN → DONE when the counter reaches WIDTH-1.
- On entry to DONE: result, carry_out and zero load from the working registers. They hold until the next DONE.
- start in RUN is ignored: no latch and no effect on the operation in flight.
- Changes on a, b or op after accept are ignored.
- rst at any time:
  - Go to IDLE.
  - Clear result, carry_out, zero, busy, done, counter and shift registers.
  - An aborted operation never pulses done.

## Timing
- Output reset values: busy=0, done=0, result=0, carry_out=0, zero=0.
  - zero resets to 0 even though result=0; it is valid only after the first done.
- Latency: if start is sampled at edge k, then busy=1 for cycles k+1 through k+WIDTH, and done=1 in cycle k+WIDTH+1.
- Total latency is WIDTH+1 cycles. With a back-to-back start in DONE, throughput is one operation per WIDTH+1 cycles.
- result, carry_out and zero change only on the edge that asserts done (or on rst).
- The counter is clog2(WIDTH) bits wide and does not wrap: it saturates at the state change.

## Configuration
- Macro: SERIAL_ALU_ADD_EN.
- Defined:
  - op 11 is ADD: sum bit is a^b^c, carry is majority(a,b,c), starting with carry 0.
  - carry_out is the final carry.
- Undefined:
  - op 11 is bitwise XNOR.
  - The carry register and carry logic are not compiled in.
  - carry_out is tied to 0.

## Structure
- alu_pkg holds:
  - op_t enum: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11.
  - state_t enum: IDLE, RUN, DONE.
- Sub-module alu_bit_slice: combinational 1-bit unit.
  - Inputs: a, b, cin, op.
  - Outputs: out, cout.
  - Contains the XOR/AND/OR/add logic.
  - The macro guards its ADD path.
- serial_alu_ctrl contains the FSM, counter, shift registers and output registers.

## Test plan
- XOR with a=0xA5, b=0x0F, WIDTH=8 → result=0xAA, zero=0, carry_out=0. busy is high for 8 cycles and done pulses exactly 9 cycles after start.
- AND with 0xF0 and 0x0F → result=0x00, zero=1. Then OR with the same operands → result=0xFF, zero=0.
- ADD with 0xFF+0x01 and the macro defined → result=0x00, carry_out=1, zero=1. ADD with 0x12+0x34 → 0x46, carry_out=0. Without the macro, op 11 with 0xF0 and 0x0F → 0x00 and carry_out=0.
- Start XOR 0x0F^0x01; then at RUN cycle 3, drive start=1 with op=AND and new operands → ignored. done pulses once, result=0x0E.
- Assert rst for one cycle at RUN cycle 4 → next cycle busy=0, all outputs 0, and no done pulse within 20 cycles.
- Assert start again in the DONE cycle with XOR 0x33^0x33 → first result visible at the first done; second done comes 9 cycles later with result=0x00 and zero=1.
